// File: rtl/ram1_uart_bus_ctrl_pkg.sv
// Shared widths, UART register addresses and FSM state encodings for the RAM1/UART bus controller.
// Also holds the helper that packs the UART status bits.
package ram1_uart_bus_ctrl_pkg;

   localparam int          DATA_BUS       = 16;
   localparam int          ADDR_BUS       = 18;
   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RR1,
      S_RR2,
      S_RW1,
      S_RW2,
      S_UR1,
      S_UR2,
      S_UR3,
      S_UW1,
      S_UW2,
      S_DONE
   } state_t;

   // Bit 1: receive data waiting; bit 0: transmitter fully idle.
   function automatic logic [1:0] status_bits(input logic data_ready_s,
                                              input logic tsre_s,
                                              input logic tbre_s);
      return {data_ready_s, tsre_s & tbre_s};
   endfunction

endpackage

// File: rtl/ram1_uart_bus_ctrl_uart_status_sync.sv
// Two-flop synchroniser for the three asynchronous UART status pins.
// Both stages clear to 0 on reset.
module uart_status_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_tsre,
   input  logic i_tbre,
   input  logic i_data_ready,
   output logic o_tsre_s,
   output logic o_tbre_s,
   output logic o_data_ready_s
);

   logic [2:0] w_async;
   logic [2:0] r_meta;
   logic [2:0] r_sync;

   assign w_async = {i_data_ready, i_tbre, i_tsre};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= w_async;
         r_sync <= r_meta;
      end
   end

   assign o_tsre_s       = r_sync[0];
   assign o_tbre_s       = r_sync[1];
   assign o_data_ready_s = r_sync[2];

endmodule

// File: rtl/ram1_uart_bus_ctrl.sv
// Sequences the shared RAM1/UART data bus for the CPU MEM stage: decodes each request,
// walks the chip strobes through a fixed cycle order and returns read data with a ready pulse.
module ram1_uart_bus_ctrl
   import ram1_uart_bus_ctrl_pkg::*;
#(
   parameter int          ADDR_W      = ADDR_BUS,
   parameter int          DATA_W      = DATA_BUS,
   parameter logic [15:0] UART_DATA_A = UART_DATA_ADDR,
   parameter logic [15:0] UART_STAT_A = UART_STAT_ADDR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [15:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   inout  wire  [DATA_W-1:0] ram1_data,
   output logic [ADDR_W-1:0] ram1_addr,
   output logic              ram1_en,
   output logic              ram1_oe,
   output logic              ram1_we,
   input  logic              tsre,
   input  logic              tbre,
   input  logic              data_ready,
   output logic              rdn,
   output logic              wrn
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] w_status;
   logic              w_tsre_s;
   logic              w_tbre_s;
   logic              w_data_ready_s;
   logic              w_is_data;
   logic              w_is_stat;
   logic              w_accept;
   logic              w_drive;

   uart_status_sync u_status_sync (
      .clk            (clk),
      .rst            (rst),
      .i_tsre         (tsre),
      .i_tbre         (tbre),
      .i_data_ready   (data_ready),
      .o_tsre_s       (w_tsre_s),
      .o_tbre_s       (w_tbre_s),
      .o_data_ready_s (w_data_ready_s)
   );

   assign w_is_data = (addr == UART_DATA_A);
   assign w_is_stat = (addr == UART_STAT_A);
   assign w_accept  = (r_state == S_IDLE) && req;

   always_comb begin
      w_status      = '0;
      w_status[1:0] = status_bits(w_data_ready_s, w_tsre_s, w_tbre_s);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (w_is_stat)      w_next = S_DONE;
               else if (w_is_data) w_next = we ? S_UW1 : (w_data_ready_s ? S_UR1 : S_DONE);
               else                w_next = we ? S_RW1 : S_RR1;
            end
         end
         S_RR1:   w_next = S_RR2;
         S_RW1:   w_next = S_RW2;
         S_UR1:   w_next = S_UR2;
         S_UR2:   w_next = S_UR3;
         S_UW1:   w_next = S_UW2;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes decode straight from the state register so an async reset releases them at once.
   always_comb begin
      ram1_en = 1'b1;
      ram1_oe = 1'b1;
      ram1_we = 1'b1;
      rdn     = 1'b1;
      wrn     = 1'b1;
      w_drive = 1'b0;
      ready   = 1'b0;
      case (r_state)
         S_RR1: begin ram1_en = 1'b0; ram1_oe = 1'b0; end
         S_RR2: ready = 1'b1;
         S_RW1: begin ram1_en = 1'b0; ram1_we = 1'b0; w_drive = 1'b1; end
         S_RW2: begin ram1_en = 1'b0; w_drive = 1'b1; ready = 1'b1; end
         S_UR1: rdn = 1'b0;
         S_UR2: rdn = 1'b0;
         S_UR3: ready = 1'b1;
         S_UW1: begin wrn = 1'b0; w_drive = 1'b1; end
         S_UW2: begin w_drive = 1'b1; ready = 1'b1; end
         S_DONE: ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= ADDR_W'(addr);
            r_wdata <= wdata;
            if (!we && w_is_stat)
               r_rdata <= w_status;
            else if (!we && w_is_data && !w_data_ready_s)
               r_rdata <= '0;
         end
         // Capture while the strobe is still low so rdata is valid throughout the ready cycle.
         if (r_state == S_RR1 || r_state == S_UR2)
            r_rdata <= ram1_data;
      end
   end

   assign ram1_data = w_drive ? r_wdata : {DATA_W{1'bz}};
   assign ram1_addr = r_addr;
   assign rdata     = r_rdata;

endmodule

// File: tb/tb_ram1_uart_bus_ctrl.sv
// Self-checking bench for ram1_uart_bus_ctrl: RAM/UART pin models, an expectation model feeding
// a scoreboard queue, and a bus-release probe after every transaction.
module tb_ram1_uart_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [15:0] rdata;
   logic        ready;
   wire  [15:0] ram1_data;
   logic [17:0] ram1_addr;
   logic        ram1_en, ram1_oe, ram1_we;
   logic        tsre = 1'b0, tbre = 1'b0, data_ready = 1'b0;
   logic        rdn, wrn;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] tb_mem  [0:65535];
   logic [15:0] exp_mem [0:65535];
   logic [15:0] uart_val   = 16'h0041;
   logic [15:0] last_rdata = 16'h0000;
   logic        probe_en   = 1'b0;
   logic [15:0] probe_val  = 16'h5A5A;
   logic        tb_drv_en;
   logic [15:0] tb_drv_val;

   typedef struct {
      logic [15:0] rdata;
      int          lat;
      int          n_en, n_oe, n_we, n_rdn, n_wrn;
      bit          is_ram;
      bit          is_wr;
      logic [15:0] wdata;
      logic [17:0] addr;
   } sb_t;

   sb_t sb_q[$];

   always #5 clk = ~clk;

   ram1_uart_bus_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .ram1_data  (ram1_data),
      .ram1_addr  (ram1_addr),
      .ram1_en    (ram1_en),
      .ram1_oe    (ram1_oe),
      .ram1_we    (ram1_we),
      .tsre       (tsre),
      .tbre       (tbre),
      .data_ready (data_ready),
      .rdn        (rdn),
      .wrn        (wrn)
   );

   // Pin models: SRAM drives while en/oe low, UART drives while rdn low, probe tests bus release.
   always_comb begin
      tb_drv_en  = probe_en || (!ram1_en && !ram1_oe) || !rdn;
      tb_drv_val = probe_en ? probe_val : (!rdn ? uart_val : tb_mem[ram1_addr[15:0]]);
   end
   assign ram1_data = tb_drv_en ? tb_drv_val : 16'bz;

   always @(posedge clk) begin
      if (!ram1_en && !ram1_we)
         tb_mem[ram1_addr[15:0]] <= ram1_data;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic sb_t model(input logic i_we, input logic [15:0] i_addr,
                                 input logic [15:0] i_wdata);
      sb_t e;
      e.n_en = 0; e.n_oe = 0; e.n_we = 0; e.n_rdn = 0; e.n_wrn = 0;
      e.is_ram = 1'b0;
      e.is_wr  = i_we;
      e.wdata  = i_wdata;
      e.addr   = {2'b00, i_addr};
      if (i_addr == 16'hBF01) begin
         e.lat = 1;
         if (!i_we) last_rdata = {14'b0, data_ready, tsre & tbre};
      end else if (i_addr == 16'hBF00) begin
         if (i_we) begin
            e.lat = 2; e.n_wrn = 1;
         end else if (data_ready) begin
            e.lat = 3; e.n_rdn = 2; last_rdata = uart_val;
         end else begin
            e.lat = 1; last_rdata = 16'h0000;
         end
      end else begin
         e.is_ram = 1'b1;
         e.lat    = 2;
         if (i_we) begin
            e.n_en = 2; e.n_we = 1; exp_mem[i_addr] = i_wdata;
         end else begin
            e.n_en = 1; e.n_oe = 1; last_rdata = exp_mem[i_addr];
         end
      end
      e.rdata = last_rdata;
      return e;
   endfunction

   task automatic bus_released(input string tag);
      probe_en  = 1'b1;
      probe_val = 16'h5A5A;
      #1;
      check_val(tag, ram1_data, 16'h5A5A);
      probe_en  = 1'b0;
   endtask

   task automatic run_op(input logic i_we, input logic [15:0] i_addr, input logic [15:0] i_wdata);
      sb_t         e;
      int          cyc = 0;
      bit          got = 1'b0;
      int          c_en = 0, c_oe = 0, c_we = 0, c_rdn = 0, c_wrn = 0, c_both = 0;
      logic [15:0] bus_cap = '0;
      logic [17:0] addr_cap = '0;
      repeat (3) @(negedge clk);
      sb_q.push_back(model(i_we, i_addr, i_wdata));
      req = 1'b1; we = i_we; addr = i_addr; wdata = i_wdata;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (!ram1_en) begin c_en++; addr_cap = ram1_addr; end
         if (!ram1_oe) c_oe++;
         if (!ram1_we) begin c_we++; bus_cap = ram1_data; end
         if (!rdn) c_rdn++;
         if (!wrn) begin c_wrn++; bus_cap = ram1_data; end
         if (!ram1_en && (!rdn || !wrn)) c_both++;
         if (ready) got = 1'b1;
         else if (cyc == 1) begin
            // Inputs change mid-operation; the latched request must be unaffected.
            we = ~i_we; addr = ~i_addr; wdata = ~i_wdata;
         end
      end
      req = 1'b0;
      e = sb_q.pop_front();
      if (!got) begin
         check_val("ready_timeout", 32'(cyc), 32'(e.lat));
         return;
      end
      $display("op we=%0b addr=%04h wdata=%04h lat=%0d rdata=%04h", i_we, i_addr, i_wdata, cyc, rdata);
      check_val("latency", 32'(cyc), 32'(e.lat));
      check_val("rdata", rdata, e.rdata);
      check_val("n_en", 32'(c_en), 32'(e.n_en));
      check_val("n_oe", 32'(c_oe), 32'(e.n_oe));
      check_val("n_we", 32'(c_we), 32'(e.n_we));
      check_val("n_rdn", 32'(c_rdn), 32'(e.n_rdn));
      check_val("n_wrn", 32'(c_wrn), 32'(e.n_wrn));
      check_val("en_and_uart", 32'(c_both), 32'd0);
      if (e.is_ram) check_val("ram_addr", addr_cap, e.addr);
      if (e.is_wr && (e.is_ram || e.n_wrn != 0)) check_val("wr_bus", bus_cap, e.wdata);
      @(negedge clk);
      check_val("ready_pulse", ready, 1'b0);
      check_val("idle_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'h1F);
      bus_released("bus_release");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         tb_mem[i]  = 16'h0000;
         exp_mem[i] = 16'h0000;
      end
      tb_mem[16'h0123] = 16'hBEEF; exp_mem[16'h0123] = 16'hBEEF;
      tb_mem[16'h0077] = 16'h7777; exp_mem[16'h0077] = 16'h7777;

      repeat (2) @(negedge clk);
      check_val("rst_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'h1F);
      check_val("rst_addr", ram1_addr, 18'h0);
      check_val("rst_rdata", rdata, 16'h0);
      check_val("rst_ready", ready, 1'b0);
      bus_released("rst_bus");
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 16'h0123, 16'h0000);
      run_op(1'b1, 16'h0040, 16'h1234);
      run_op(1'b0, 16'h0040, 16'h0000);

      tsre = 1'b1; tbre = 1'b1; data_ready = 1'b1;
      run_op(1'b0, 16'hBF01, 16'h0000);
      uart_val = 16'h0041;
      run_op(1'b0, 16'hBF00, 16'h0000);
      data_ready = 1'b0; tbre = 1'b0;
      run_op(1'b0, 16'hBF01, 16'h0000);
      run_op(1'b0, 16'h0123, 16'h0000);
      run_op(1'b0, 16'hBF00, 16'h0000);
      run_op(1'b1, 16'hBF00, 16'h0055);
      run_op(1'b1, 16'hBF01, 16'hFFFF);
      run_op(1'b1, 16'hBF02, 16'hC0DE);
      run_op(1'b1, 16'hBEFF, 16'hF00D);
      run_op(1'b1, 16'hFFFF, 16'h8001);
      run_op(1'b0, 16'hBF02, 16'h0000);
      run_op(1'b0, 16'hBEFF, 16'h0000);
      run_op(1'b0, 16'hFFFF, 16'h0000);

      // Abort a RAM write in its first cycle; the target word must keep its old contents.
      repeat (3) @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0077; wdata = 16'hDEAD;
      @(negedge clk);
      check_val("abort_pre_we", ram1_we, 1'b0);
      rst = 1'b1;
      #1;
      check_val("abort_we", ram1_we, 1'b1);
      check_val("abort_en", ram1_en, 1'b1);
      check_val("abort_ready", ready, 1'b0);
      req = 1'b0;
      bus_released("abort_bus");
      last_rdata = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b0, 16'h0077, 16'h0000);
      run_op(1'b1, 16'h0077, 16'h4321);
      run_op(1'b0, 16'h0077, 16'h0000);

      for (int i = 0; i < 8; i++) begin
         logic [15:0] ra;
         logic [15:0] rd;
         ra = 16'h0200 + 16'($urandom_range(0, 7));
         rd = 16'($urandom);
         run_op(1'($urandom_range(0, 1)), ra, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
